// File: rtl/jtag_tap_os_pkg.sv
// Shared types and helpers for the oversampled JTAG TAP responder.
// Holds the 1149.1 state encoding, fixed IR opcodes and the TAP next-state function.
package jtag_tap_os_pkg;

  typedef enum logic [3:0] {
    EX2_DR = 4'h0,
    EX1_DR = 4'h1,
    SH_DR  = 4'h2,
    PA_DR  = 4'h3,
    SEL_IR = 4'h4,
    UPD_DR = 4'h5,
    CAP_DR = 4'h6,
    SEL_DR = 4'h7,
    EX2_IR = 4'h8,
    EX1_IR = 4'h9,
    SH_IR  = 4'hA,
    PA_IR  = 4'hB,
    RTI    = 4'hC,
    UPD_IR = 4'hD,
    CAP_IR = 4'hE,
    TLR    = 4'hF
  } tap_state_e;

  localparam logic [4:0] IR_IDCODE = 5'h01;
  localparam logic [4:0] IR_BYPASS = 5'h1F;
  localparam int unsigned IdcodeDrW = 32;

  // Standard 1149.1 state transition on a TCK rising edge.
  function automatic tap_state_e next_state(input tap_state_e s, input logic tms);
    tap_state_e n;
    n = s;
    case (s)
      TLR:     n = tms ? TLR    : RTI;
      RTI:     n = tms ? SEL_DR : RTI;
      SEL_DR:  n = tms ? SEL_IR : CAP_DR;
      CAP_DR:  n = tms ? EX1_DR : SH_DR;
      SH_DR:   n = tms ? EX1_DR : SH_DR;
      EX1_DR:  n = tms ? UPD_DR : PA_DR;
      PA_DR:   n = tms ? EX2_DR : PA_DR;
      EX2_DR:  n = tms ? UPD_DR : SH_DR;
      UPD_DR:  n = tms ? SEL_DR : RTI;
      SEL_IR:  n = tms ? TLR    : CAP_IR;
      CAP_IR:  n = tms ? EX1_IR : SH_IR;
      SH_IR:   n = tms ? EX1_IR : SH_IR;
      EX1_IR:  n = tms ? UPD_IR : PA_IR;
      PA_IR:   n = tms ? EX2_IR : PA_IR;
      EX2_IR:  n = tms ? UPD_IR : SH_IR;
      UPD_IR:  n = tms ? SEL_DR : RTI;
      default: n = TLR;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/jtag_tap_os_sync.sv
// Two-flop synchronizers for the JTAG pins plus registered TCK edge pulses.
module jtag_tap_os_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic tck_i,
  input  logic tms_i,
  input  logic tdi_i,
  input  logic trst_ni,
  output logic tms_s_o,
  output logic tdi_s_o,
  output logic trst_ns_o,
  output logic tck_rise_o,
  output logic tck_fall_o
);

  logic [1:0] tck_q, tms_q, tdi_q, trst_q;
  logic       tck_prev_q;
  logic       rise_q, fall_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tck_q      <= '0;
      tms_q      <= '0;
      tdi_q      <= '0;
      trst_q     <= 2'b11;
      tck_prev_q <= 1'b0;
      rise_q     <= 1'b0;
      fall_q     <= 1'b0;
    end else begin
      tck_q      <= {tck_q[0], tck_i};
      tms_q      <= {tms_q[0], tms_i};
      tdi_q      <= {tdi_q[0], tdi_i};
      trst_q     <= {trst_q[0], trst_ni};
      tck_prev_q <= tck_q[1];
      rise_q     <= tck_q[1] & ~tck_prev_q;
      fall_q     <= ~tck_q[1] & tck_prev_q;
    end
  end

  assign tms_s_o    = tms_q[1];
  assign tdi_s_o    = tdi_q[1];
  assign trst_ns_o  = trst_q[1];
  assign tck_rise_o = rise_q;
  assign tck_fall_o = fall_q;

endmodule

// File: rtl/jtag_tap_os.sv
// Clock-synchronous 1149.1 TAP responder with IDCODE, BYPASS and one USER DR.
// Define JTAG_TAP_OS_TRST_EN to let jtag_trst_ni force Test-Logic-Reset.
module jtag_tap_os
  import jtag_tap_os_pkg::*;
#(
  parameter int unsigned    IrW         = 5,
  parameter int unsigned    UserDrW     = 32,
  parameter logic [31:0]    IdCodeValue = 32'h2000_1A3B,
  parameter logic [IrW-1:0] UserInstr   = IrW'(5'h10)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               jtag_tck_i,
  input  logic               jtag_tms_i,
  input  logic               jtag_trst_ni,
  input  logic               jtag_td_i,
  output logic               jtag_td_o,
  output logic               jtag_tdo_oe_o,
  input  logic [UserDrW-1:0] user_capture_i,
  output logic               user_update_valid_o,
  output logic [UserDrW-1:0] user_update_data_o,
  output logic [3:0]         tap_state_o
);

  localparam int unsigned    DrW      = (UserDrW > IdcodeDrW) ? UserDrW : IdcodeDrW;
  localparam int unsigned    IdxW     = $clog2(DrW);
  localparam logic [IrW-1:0] IdcodeOp = IrW'(IR_IDCODE);

  logic tms_s, tdi_s, trst_ns, tck_rise, tck_fall, trst_active;

  jtag_tap_os_sync u_sync (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .tck_i      (jtag_tck_i),
    .tms_i      (jtag_tms_i),
    .tdi_i      (jtag_td_i),
    .trst_ni    (jtag_trst_ni),
    .tms_s_o    (tms_s),
    .tdi_s_o    (tdi_s),
    .trst_ns_o  (trst_ns),
    .tck_rise_o (tck_rise),
    .tck_fall_o (tck_fall)
  );

`ifdef JTAG_TAP_OS_TRST_EN
  assign trst_active = ~trst_ns;
`else
  logic unused_trst_ns;
  assign unused_trst_ns = trst_ns;
  assign trst_active    = 1'b0;
`endif

  tap_state_e         state_q, state_d;
  logic [IrW-1:0]     ir_q, ir_d, ir_sr_q, ir_sr_d;
  logic [DrW-1:0]     dr_sr_q, dr_sr_d, dr_shift, dr_cap;
  logic [IdxW-1:0]    dr_msb;
  logic               td_q, td_d, oe_q, oe_d;
  logic               upd_valid_q, upd_valid_d;
  logic [UserDrW-1:0] upd_data_q, upd_data_d;
  logic               in_shift;

  // Selected DR length and capture value follow the current instruction.
  always_comb begin
    dr_msb = '0;
    dr_cap = '0;
    if (ir_q == IdcodeOp) begin
      dr_msb = IdxW'(IdcodeDrW - 1);
      dr_cap = DrW'(IdCodeValue);
    end else if (ir_q == UserInstr) begin
      dr_msb = IdxW'(UserDrW - 1);
      dr_cap = DrW'(user_capture_i);
    end
  end

  always_comb begin
    dr_shift         = {1'b0, dr_sr_q[DrW-1:1]};
    dr_shift[dr_msb] = tdi_s;
  end

  assign in_shift = (state_q == SH_DR) || (state_q == SH_IR);

  always_comb begin
    state_d     = state_q;
    ir_d        = ir_q;
    ir_sr_d     = ir_sr_q;
    dr_sr_d     = dr_sr_q;
    td_d        = td_q;
    oe_d        = oe_q;
    upd_valid_d = 1'b0;
    upd_data_d  = upd_data_q;

    if (trst_active) begin
      state_d = TLR;
      ir_d    = IdcodeOp;
    end else if (tck_rise) begin
      state_d = next_state(state_q, tms_s);
      if (state_q == SH_DR) dr_sr_d = dr_shift;
      if (state_q == SH_IR) ir_sr_d = {tdi_s, ir_sr_q[IrW-1:1]};
      // Entry actions keyed on the state being entered at this edge.
      case (state_d)
        CAP_IR: ir_sr_d = IrW'(1);
        CAP_DR: dr_sr_d = dr_cap;
        UPD_IR: ir_d = ir_sr_q;
        UPD_DR: begin
          if (ir_q == UserInstr) begin
            upd_data_d  = dr_sr_q[UserDrW-1:0];
            upd_valid_d = 1'b1;
          end
        end
        TLR:     ir_d = IdcodeOp;
        default: ;
      endcase
    end

    if (!in_shift) begin
      td_d = 1'b0;
      oe_d = 1'b0;
    end else if (tck_fall) begin
      td_d = (state_q == SH_IR) ? ir_sr_q[0] : dr_sr_q[0];
      oe_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= TLR;
      ir_q        <= IdcodeOp;
      ir_sr_q     <= '0;
      dr_sr_q     <= '0;
      td_q        <= 1'b0;
      oe_q        <= 1'b0;
      upd_valid_q <= 1'b0;
      upd_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      ir_q        <= ir_d;
      ir_sr_q     <= ir_sr_d;
      dr_sr_q     <= dr_sr_d;
      td_q        <= td_d;
      oe_q        <= oe_d;
      upd_valid_q <= upd_valid_d;
      upd_data_q  <= upd_data_d;
    end
  end

  assign jtag_td_o           = td_q;
  assign jtag_tdo_oe_o       = oe_q;
  assign user_update_valid_o = upd_valid_q;
  assign user_update_data_o  = upd_data_q;
  assign tap_state_o         = 4'(state_q);

endmodule

// File: tb/tb_jtag_tap_os.sv
// Directed bench for jtag_tap_os: IDCODE, TMS reset, BYPASS, USER DR, rst_i and trst.
module tb_jtag_tap_os;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tck = 1'b0, tms = 1'b1, tdi = 1'b0, trst_n = 1'b1;
  logic        td_o, oe_o, upd_valid;
  logic [31:0] user_cap = '0, upd_data;
  logic [3:0]  tap_state;

  int errors = 0;
  int checks = 0;
  int valid_cnt = 0;
  logic tdo_smp, oe_smp;

  jtag_tap_os dut (
    .clk_i               (clk),
    .rst_i               (rst),
    .jtag_tck_i          (tck),
    .jtag_tms_i          (tms),
    .jtag_trst_ni        (trst_n),
    .jtag_td_i           (tdi),
    .jtag_td_o           (td_o),
    .jtag_tdo_oe_o       (oe_o),
    .user_capture_i      (user_cap),
    .user_update_valid_o (upd_valid),
    .user_update_data_o  (upd_data),
    .tap_state_o         (tap_state)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (upd_valid) valid_cnt++;

  // One TCK period: 5 clk low (TDO sampled at its end), then 5 clk high.
  task automatic tck_cycle(input logic t_ms, input logic t_di);
    tck = 1'b0; tms = t_ms; tdi = t_di;
    repeat (5) @(negedge clk);
    tdo_smp = td_o; oe_smp = oe_o;
    tck = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  // RTI -> shift n DR bits -> Update-DR -> RTI.
  task automatic shift_dr(input int n, input logic [63:0] din, output logic [63:0] dout,
                          output logic oe_ok, output logic oe_after);
    dout = '0; oe_ok = 1'b1;
    tck_cycle(1'b1, 1'b0); tck_cycle(1'b0, 1'b0); tck_cycle(1'b0, 1'b0);
    for (int i = 0; i < n; i++) begin
      tck_cycle(i == n - 1, din[i]);
      dout[i] = tdo_smp;
      oe_ok   = oe_ok & oe_smp;
    end
    tck_cycle(1'b1, 1'b0);
    oe_after = oe_smp;
    tck_cycle(1'b0, 1'b0);
  endtask

  // RTI -> shift 5 IR bits -> Update-IR -> RTI.
  task automatic shift_ir(input logic [4:0] din, output logic [4:0] dout);
    dout = '0;
    tck_cycle(1'b1, 1'b0); tck_cycle(1'b1, 1'b0); tck_cycle(1'b0, 1'b0); tck_cycle(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tck_cycle(i == 4, din[i]);
      dout[i] = tdo_smp;
    end
    tck_cycle(1'b1, 1'b0); tck_cycle(1'b0, 1'b0);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (tap_state !== 4'hF) begin errors++; $display("FAIL reset_state got=%h exp=F", tap_state); end
    checks++; if (td_o !== 1'b0) begin errors++; $display("FAIL reset_td got=%b exp=0", td_o); end
    checks++; if (oe_o !== 1'b0) begin errors++; $display("FAIL reset_oe got=%b exp=0", oe_o); end
    checks++; if (upd_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", upd_valid); end
    checks++; if (upd_data !== 32'h0) begin errors++; $display("FAIL reset_data got=%h exp=0", upd_data); end
  endtask

  task automatic test_idcode();
    logic [63:0] dout; logic ok, after;
    tck_cycle(1'b0, 1'b0);
    shift_dr(32, 64'h0, dout, ok, after);
    checks++; if (dout[31:0] !== 32'h2000_1A3B) begin errors++; $display("FAIL idcode got=%h exp=20001a3b", dout[31:0]); end
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL idcode_oe_shift got=%b exp=1", ok); end
    checks++; if (after !== 1'b0) begin errors++; $display("FAIL idcode_oe_after got=%b exp=0", after); end
  endtask

  task automatic test_tms_reset();
    logic [7:0] pbits[16]; int plen[16]; logic [3:0] pst[16];
    logic [63:0] dout; logic [4:0] irout; logic ok, after;
    // TMS paths from RTI (LSB first) and the 1149.1 encoding reached.
    pbits[0]  = 8'b111;    plen[0]  = 3; pst[0]  = 4'hF;
    pbits[1]  = 8'b0;      plen[1]  = 0; pst[1]  = 4'hC;
    pbits[2]  = 8'b1;      plen[2]  = 1; pst[2]  = 4'h7;
    pbits[3]  = 8'b01;     plen[3]  = 2; pst[3]  = 4'h6;
    pbits[4]  = 8'b001;    plen[4]  = 3; pst[4]  = 4'h2;
    pbits[5]  = 8'b101;    plen[5]  = 3; pst[5]  = 4'h1;
    pbits[6]  = 8'b0101;   plen[6]  = 4; pst[6]  = 4'h3;
    pbits[7]  = 8'b10101;  plen[7]  = 5; pst[7]  = 4'h0;
    pbits[8]  = 8'b1101;   plen[8]  = 4; pst[8]  = 4'h5;
    pbits[9]  = 8'b11;     plen[9]  = 2; pst[9]  = 4'h4;
    pbits[10] = 8'b011;    plen[10] = 3; pst[10] = 4'hE;
    pbits[11] = 8'b0011;   plen[11] = 4; pst[11] = 4'hA;
    pbits[12] = 8'b1011;   plen[12] = 4; pst[12] = 4'h9;
    pbits[13] = 8'b01011;  plen[13] = 5; pst[13] = 4'hB;
    pbits[14] = 8'b101011; plen[14] = 6; pst[14] = 4'h8;
    pbits[15] = 8'b11011;  plen[15] = 5; pst[15] = 4'hD;
    for (int s = 0; s < 16; s++) begin
      shift_ir(5'h1F, irout);
      for (int j = 0; j < plen[s]; j++) tck_cycle(pbits[s][j], 1'b0);
      repeat (2) @(negedge clk);
      checks++; if (tap_state !== pst[s]) begin errors++; $display("FAIL path_%0d got=%h exp=%h", s, tap_state, pst[s]); end
      for (int j = 0; j < 5; j++) tck_cycle(1'b1, 1'b0);
      checks++; if (tap_state !== 4'hF) begin errors++; $display("FAIL tlr_from_%0d got=%h exp=F", s, tap_state); end
      tck_cycle(1'b0, 1'b0);
      shift_dr(32, 64'h0, dout, ok, after);
      checks++; if (dout[31:0] !== 32'h2000_1A3B) begin errors++; $display("FAIL ir_idcode_%0d got=%h exp=20001a3b", s, dout[31:0]); end
    end
  endtask

  task automatic test_bypass();
    logic [63:0] dout; logic [4:0] irout; logic ok, after; int vc;
    shift_ir(5'h1F, irout);
    checks++; if (irout !== 5'b00001) begin errors++; $display("FAIL ir_capture got=%b exp=00001", irout); end
    vc = valid_cnt;
    shift_dr(9, 64'h0A5, dout, ok, after);
    checks++; if (dout[8:0] !== 9'h14A) begin errors++; $display("FAIL bypass got=%h exp=14a", dout[8:0]); end
    checks++; if (valid_cnt !== vc) begin errors++; $display("FAIL bypass_no_update got=%0d exp=%0d", valid_cnt, vc); end
  endtask

  task automatic test_user();
    logic [63:0] dout; logic [4:0] irout; logic ok, after; int vc;
    shift_ir(5'h10, irout);
    user_cap = 32'hDEADBEEF;
    vc = valid_cnt;
    shift_dr(32, 64'h1234_5678, dout, ok, after);
    checks++; if (dout[31:0] !== 32'hDEADBEEF) begin errors++; $display("FAIL user_tdo got=%h exp=deadbeef", dout[31:0]); end
    checks++; if (valid_cnt !== vc + 1) begin errors++; $display("FAIL user_pulse got=%0d exp=%0d", valid_cnt - vc, 1); end
    checks++; if (upd_data !== 32'h1234_5678) begin errors++; $display("FAIL user_data got=%h exp=12345678", upd_data); end
  endtask

  task automatic test_rst_mid_shift();
    logic [63:0] dout; logic [4:0] irout; logic ok, after; int vc;
    user_cap = 32'h5555_AAAA;
    tck_cycle(1'b1, 1'b0); tck_cycle(1'b0, 1'b0); tck_cycle(1'b0, 1'b0);
    for (int i = 0; i < 10; i++) tck_cycle(1'b0, 1'b1);
    vc = valid_cnt;
    tck = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (tap_state !== 4'hF) begin errors++; $display("FAIL rst_state got=%h exp=F", tap_state); end
    checks++; if (td_o !== 1'b0) begin errors++; $display("FAIL rst_td got=%b exp=0", td_o); end
    checks++; if (oe_o !== 1'b0) begin errors++; $display("FAIL rst_oe got=%b exp=0", oe_o); end
    checks++; if (upd_data !== 32'h0) begin errors++; $display("FAIL rst_data got=%h exp=0", upd_data); end
    for (int i = 0; i < 6; i++) tck_cycle(1'b1, 1'b0);
    checks++; if (valid_cnt !== vc) begin errors++; $display("FAIL rst_no_pulse got=%0d exp=%0d", valid_cnt, vc); end
    tck_cycle(1'b0, 1'b0);
    shift_ir(5'h10, irout);
    user_cap = 32'hCAFE_F00D;
    shift_dr(32, 64'h0BAD_F00D, dout, ok, after);
    checks++; if (dout[31:0] !== 32'hCAFE_F00D) begin errors++; $display("FAIL post_rst_tdo got=%h exp=cafef00d", dout[31:0]); end
    checks++; if (upd_data !== 32'h0BAD_F00D) begin errors++; $display("FAIL post_rst_data got=%h exp=0badf00d", upd_data); end
    checks++; if (valid_cnt !== vc + 1) begin errors++; $display("FAIL post_rst_pulse got=%0d exp=%0d", valid_cnt - vc, 1); end
  endtask

  task automatic test_trst();
    logic [3:0] exp_st;
`ifdef JTAG_TAP_OS_TRST_EN
    exp_st = 4'hF;
`else
    exp_st = 4'h3;
`endif
    tck_cycle(1'b1, 1'b0); tck_cycle(1'b0, 1'b0); tck_cycle(1'b1, 1'b0); tck_cycle(1'b0, 1'b0);
    tck = 1'b0;
    repeat (5) @(negedge clk);
    checks++; if (tap_state !== 4'h3) begin errors++; $display("FAIL trst_pre got=%h exp=3", tap_state); end
    trst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (tap_state !== exp_st) begin errors++; $display("FAIL trst_state got=%h exp=%h", tap_state, exp_st); end
    repeat (4) @(negedge clk);
    checks++; if (tap_state !== exp_st) begin errors++; $display("FAIL trst_hold got=%h exp=%h", tap_state, exp_st); end
    trst_n = 1'b1;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 5; i++) tck_cycle(1'b1, 1'b0);
    checks++; if (tap_state !== 4'hF) begin errors++; $display("FAIL trst_exit got=%h exp=F", tap_state); end
  endtask

  initial begin
    test_reset();
    test_idcode();
    test_tms_reset();
    test_bypass();
    test_user();
    test_rst_mid_shift();
    test_trst();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
